// File: rtl/spi_pkg.sv
// Shared types and mode constants for the clk-domain SPI slave.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } spi_slave_state_t;

    localparam int CPOL_LOW   = 0;
    localparam int CPOL_HIGH  = 1;
    localparam int CPHA_LEAD  = 0;
    localparam int CPHA_TRAIL = 1;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= {STAGES{RST_VAL}};
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave with every pin oversampled on clk; one holding register feeds
// the TX shifter so words can stream back-to-back inside one CS_L frame.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CS_L,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_err
);

    localparam int   CW        = $clog2(WIDTH + 1);
    localparam logic SCLK_IDLE = (CPOL == CPOL_HIGH);

    spi_slave_state_t state;

    logic cs_s, sclk_s, mosi_s;
    logic cs_d, sclk_d;
    logic [SYNC_STAGES-1:0] flush;
    logic armed;

    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [CW-1:0]    cnt;
    logic             loaded;
    logic             pend;

    logic rise, fall, lead, trail, sample, shift;
    logic cs_fall, cs_rise, xfer, last, tx_bit;
    logic [WIDTH-1:0] rx_next, tx_next;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(CS_L), .q(cs_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s)
    );

    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign lead    = (CPOL == CPOL_LOW) ? rise : fall;
    assign trail   = (CPOL == CPOL_HIGH) ? rise : fall;
    assign sample  = (CPHA == CPHA_LEAD) ? lead : trail;
    assign shift   = (CPHA == CPHA_TRAIL) ? lead : trail;
    assign cs_fall = cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;

    assign xfer    = tx_valid & ~hold_full;
    assign last    = (cnt == CW'(WIDTH - 1));
    assign rx_next = (MSB_FIRST != 0) ? {rx_sr[WIDTH-2:0], mosi_s}
                                      : {mosi_s, rx_sr[WIDTH-1:1]};
    assign tx_next = (MSB_FIRST != 0) ? {tx_sr[WIDTH-2:0], 1'b0}
                                      : {1'b0, tx_sr[WIDTH-1:1]};
    assign tx_bit  = (MSB_FIRST != 0) ? tx_sr[WIDTH-1] : tx_sr[0];

    assign tx_ready = ~hold_full;
    assign miso_oe  = ~cs_s;
    assign MISO     = miso_oe & tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cs_d        <= 1'b1;
            sclk_d      <= SCLK_IDLE;
            flush       <= '0;
            armed       <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            cnt         <= '0;
            loaded      <= 1'b0;
            pend        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            cs_d        <= cs_s;
            sclk_d      <= sclk_s;
            flush       <= {flush[SYNC_STAGES-2:0], 1'b1};
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            // a CS_L held low through reset must go high before it can frame
            if (flush[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
            if (xfer) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (cs_fall && armed) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (cs_rise) begin
                        state  <= ST_IDLE;
                        tx_sr  <= '0;
                        loaded <= 1'b0;
                        pend   <= 1'b0;
                    end else begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        rx_sr <= '0;
                        if (hold_full) begin
                            tx_sr     <= hold;
                            hold_full <= 1'b0;
                            loaded    <= 1'b1;
                            pend      <= 1'b0;
                        end else if (xfer) begin
                            tx_sr     <= tx_data;
                            hold_full <= 1'b0;
                            loaded    <= 1'b1;
                            pend      <= 1'b0;
                        end else begin
                            tx_sr  <= '0;
                            loaded <= 1'b0;
                            pend   <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state     <= ST_IDLE;
                        frame_err <= (cnt != '0);
                        cnt       <= '0;
                        rx_sr     <= '0;
                        tx_sr     <= '0;
                        loaded    <= 1'b0;
                        pend      <= 1'b0;
                        // an untouched word loaded at frame end goes back
                        if (cnt == '0 && loaded && !hold_full && !xfer) begin
                            hold      <= tx_sr;
                            hold_full <= 1'b1;
                        end
                    end else begin
                        // underrun is reported only once the word really starts
                        if (sample) begin
                            rx_sr <= rx_next;
                            cnt   <= cnt + CW'(1);
                            if (cnt == '0) begin
                                tx_underrun <= pend;
                                pend        <= 1'b0;
                            end
                            if (last) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                                state    <= ST_LOAD;
                            end
                        end
                        if (shift && cnt != '0) tx_sr <= tx_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
